// File: rtl/uart_rx_sniffer_if.sv
// rtl/uart_rx_sniffer_if.sv - decoded byte stream handshake between sniffer and consumer
//
// Purpose: carries the FIFO head byte and its valid/ready handshake.
// Signals:
//   rx_data_o   FIFO head byte (0 when empty), driven by the sniffer
//   rx_valid_o  FIFO non-empty, driven by the sniffer
//   rx_ready_i  consumer accepts the head byte, driven by the consumer
// Modports: master = sniffer side, slave = consumer side.

interface uart_rx_sniffer_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx_sniffer.sv
// rtl/uart_rx_sniffer.sv - 8N1 UART receiver with show-ahead byte FIFO and error reporting
//
// Purpose: decodes the serial pad stream (LSB first) and buffers bytes in a FIFO.
// Ports:
//   clk_i         system clock
//   rst_n_i       synchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   clr_i         clears the sticky overflow flag
//   rx_if         master side of the byte stream (rx_data_o/rx_valid_o/rx_ready_i)
//   frame_err_o   one-cycle pulse on a bad stop bit
//   overflow_o    sticky: a byte was dropped because the FIFO was full
//   fifo_count_o  number of entries held (0..FIFO_DEPTH)
//   busy_o        receive FSM not idle

module uart_rx_sniffer #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          rx_i,
    input  logic                          clr_i,
    uart_rx_sniffer_if.master             rx_if,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          sync1_q, rx_s_q;
    state_t        state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, pop, do_push;

    // Receive FSM: the timer counts down to zero and each state acts on expiry.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (state_q != S_IDLE && state_q != S_WAIT_IDLE && timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = S_START;
                    bit_cnt_d = 3'd0;
                    timer_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (timer_q == 16'd0) begin
                    // A line that is high again at mid start bit was a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                    timer_d = FULL_LOAD;
                end
            end
            S_DATA: begin
                if (timer_q == 16'd0) begin
                    shift_d[bit_cnt_q] = rx_s_q;
                    timer_d            = FULL_LOAD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Returning to IDLE at the stop midpoint lets a back-to-back
                // start edge half a bit later be caught.
                if (timer_q == 16'd0) begin
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A held break must not retrigger start detection.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO: a push while full is accepted only if a pop frees the slot in the same cycle.
    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        empty      = (count_q == '0);
        pop        = !empty && rx_if.rx_ready_i;
        do_push    = push && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(pop);
        if (clr_i) begin
            overflow_d = 1'b0;
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rx_if.rx_data_o  = empty ? 8'd0 : mem_q[rd_ptr_q];
    assign rx_if.rx_valid_o = !empty;
    assign frame_err_o      = frame_err_q;
    assign overflow_o       = overflow_q;
    assign fifo_count_o     = count_q;
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// tb/tb_uart_rx_sniffer.sv - scoreboard bench for uart_rx_sniffer

module tb_uart_rx_sniffer;
    localparam int CPB       = 32;
    localparam int DEPTH     = 16;
    localparam int PUSH_EDGE = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       clr;
    logic       ferr;
    logic       ovf;
    logic       busy;
    logic [4:0] cnt;

    uart_rx_sniffer_if rx_if ();

    uart_rx_sniffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rx_i         (rx),
        .clr_i        (clr),
        .rx_if        (rx_if),
        .frame_err_o  (ferr),
        .overflow_o   (ovf),
        .fifo_count_o (cnt),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         pops = 0;
    int         ferr_cycles = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every accepted byte is compared with the oldest expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) ferr_cycles++;
            if (busy) busy_seen = 1'b1;
            if (rx_if.rx_valid_o && rx_if.rx_ready_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL pop_unexpected: observed %0h expected no byte", rx_if.rx_data_o);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("pop_data", rx_if.rx_data_o, exp_b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        rx_if.rx_ready_i = 1'b1;
        while (rx_if.rx_valid_o && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", rx_if.rx_valid_o, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  rx_if.rx_data_o, 8'h00);
        chk({tag, "_valid"}, rx_if.rx_valid_o, 1'b0);
        chk({tag, "_ferr"},  ferr, 1'b0);
        chk({tag, "_ovf"},   ovf, 1'b0);
        chk({tag, "_count"}, cnt, 5'd0);
        chk({tag, "_busy"},  busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rx = 1'b1;
        clr = 1'b0;
        rst_n = 1'b0;
        rx_if.rx_ready_i = 1'b0;
        idle(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Two back-to-back frames with the consumer always ready.
        rx_if.rx_ready_i = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        idle(4);
        wait_empty(50);
        chk("t1_pops", pops, 2);
        chk("t1_ferr", ferr_cycles, 0);
        chk("t1_ovf", ovf, 1'b0);

        // Short low glitch: busy for a while, then a false start.
        busy_seen = 1'b0;
        @(posedge clk);
        #1 rx = 1'b0;
        idle(2);
        chk("busy_latency_before", busy, 1'b0);
        idle(1);
        chk("busy_latency_at3", busy, 1'b1);
        idle(9);
        rx = 1'b1;
        idle(2 * CPB);
        chk("glitch_busy_seen", busy_seen, 1'b1);
        chk("glitch_busy_end", busy, 1'b0);
        chk("glitch_count", cnt, 5'd0);
        chk("glitch_ferr", ferr_cycles, 0);

        // Bad stop bit followed by a long break, then a good frame.
        send_byte(8'h00, 1'b0);
        idle(20 * CPB);
        rx = 1'b1;
        idle(2 * CPB);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1);
        idle(4);
        wait_empty(50);
        chk("break_ferr_cycles", ferr_cycles, 1);
        chk("break_pops", pops, 3);
        chk("break_busy", busy, 1'b0);

        // Overfill with the consumer stalled.
        rx_if.rx_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        idle(4);
        chk("full_count", cnt, 5'd16);
        chk("full_ovf", ovf, 1'b1);
        chk("full_head", rx_if.rx_data_o, 8'h00);
        wait_empty(100);
        chk("drain_pops", pops, 19);
        chk("ovf_sticky", ovf, 1'b1);
        chk("drain_count", cnt, 5'd0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);

        // Full FIFO: a pop in the push cycle lets the new byte in.
        rx_if.rx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h80 + 8'(i));
            send_byte(8'h80 + 8'(i), 1'b1);
        end
        idle(4);
        chk("refill_count", cnt, 5'd16);
        chk("refill_ovf", ovf, 1'b0);
        exp_q.push_back(8'hC4);
        fork
            send_byte(8'hC4, 1'b1);
            begin
                @(posedge clk);
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1 rx_if.rx_ready_i = 1'b1;
                @(posedge clk);
                #1 rx_if.rx_ready_i = 1'b0;
            end
        join
        idle(2);
        chk("coinc_count", cnt, 5'd16);
        chk("coinc_ovf", ovf, 1'b0);
        wait_empty(100);
        chk("coinc_pops", pops, 36);
        chk("coinc_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a frame with bytes buffered.
        rx_if.rx_ready_i = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(2);
        chk("pre_reset_count", cnt, 5'd3);
        fork
            send_byte(8'hF5, 1'b1);
            begin
                @(posedge clk);
                repeat (3 + CPB / 2 + 4 * CPB + 27) @(posedge clk);
                #1 rst_n = 1'b0;
                idle(1);
                chk_reset_outputs("midreset");
                rst_n = 1'b1;
            end
        join
        idle(2 * CPB);
        rx_if.rx_ready_i = 1'b1;
        exp_q.push_back(8'h31);
        send_byte(8'h31, 1'b1);
        idle(4);
        wait_empty(50);
        chk("final_pops", pops, 37);
        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_ferr", ferr_cycles, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
